bfloat16_matrix_loader: RTL and testbench

Upstream operand stage for the bfloat16 matrix multiplier. It accepts a serial valid/ready stream of bfloat16 elements and assembles one SIZE×SIZE A matrix followed by one SIZE×SIZE B matrix into holding registers. It then pulses a start to the multiplier and holds both operands stable until the multiplier reports completion. Framing is checked against an end-of-frame marker, and malformed frames are discarded.

---
 rtl/bfloat16_matrix_loader_pkg.sv | 21 ++
 rtl/bfloat16_matrix_loader.sv | 125 ++++++++++++
 tb/tb_bfloat16_matrix_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bfloat16_matrix_loader_pkg.sv
// Shared definitions for the bfloat16 matrix multiplier datapath: default
// geometry, loader state encoding and the flat-vector element offset helper.
package bf16_mm_pkg;

  localparam int N_DEF    = 16;
  localparam int SIZE_DEF = 2;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Bit offset of element (i,j) in a row-major packed SIZE x SIZE matrix.
  function automatic int elem_lsb(input int i, input int j,
                                  input int size = SIZE_DEF,
                                  input int n = N_DEF);
    return (i * size + j) * n;
  endfunction

endpackage

// File: rtl/bfloat16_matrix_loader.sv
// Collects an A-then-B frame of bfloat16 elements from a valid/ready stream,
// launches the multiplier and holds the operands until it reports completion.
module bfloat16_matrix_loader
  import bf16_mm_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int SIZE = SIZE_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_data,
  input  logic                   in_last,
  output logic [N*SIZE*SIZE-1:0] a_flat,
  output logic [N*SIZE*SIZE-1:0] b_flat,
  output logic                   op_start,
  input  logic                   op_finish,
  output logic                   busy,
  output logic                   frame_err
);

  localparam int ELEMS = SIZE * SIZE;
  localparam int BEATS = 2 * ELEMS;
  localparam int CW    = $clog2(BEATS);

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [N*ELEMS-1:0]    a_q;
  logic [N*ELEMS-1:0]    b_q;
  logic                  in_ready_q;
  logic                  op_start_q;
  logic                  busy_q;
  logic                  frame_err_q;

  logic                  accept;
  logic                  is_final;
  logic                  bad;
  logic                  wr;

  // A beat is good only when in_last and the final count agree.
  always_comb begin
    accept   = in_valid && in_ready_q && (state_q == LOAD);
    is_final = (cnt_q == CW'(BEATS - 1));
    bad      = accept && (in_last != is_final);
    wr       = accept && !bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      op_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      op_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (accept) begin
            if (bad) begin
              frame_err_q <= 1'b1;
              cnt_q       <= '0;
            end else if (is_final) begin
              cnt_q      <= '0;
              state_q    <= FIRE;
              in_ready_q <= 1'b0;
              op_start_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        FIRE: begin
          state_q    <= WAIT;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        WAIT: begin
          if (op_finish) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: begin
          state_q    <= LOAD;
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Beat k lands in A element k, beat ELEMS+k in B element k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (wr) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int j = 0; j < SIZE; j++) begin
          if (cnt_q == CW'(i * SIZE + j))
            a_q[elem_lsb(i, j, SIZE, N) +: N] <= in_data;
          if (cnt_q == CW'(ELEMS + i * SIZE + j))
            b_q[elem_lsb(i, j, SIZE, N) +: N] <= in_data;
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign op_start  = op_start_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign a_flat    = a_q;
  assign b_flat    = b_q;

endmodule

// File: tb/tb_bfloat16_matrix_loader.sv
// Self-checking bench for bfloat16_matrix_loader (N=16, SIZE=2).
module tb_bfloat16_matrix_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic [63:0] a_flat;
  logic [63:0] b_flat;
  logic        op_start;
  logic        op_finish = 1'b0;
  logic        busy;
  logic        frame_err;

  bfloat16_matrix_loader #(.N(16), .SIZE(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .a_flat(a_flat), .b_flat(b_flat),
    .op_start(op_start), .op_finish(op_finish),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  int beats = 0;
  logic [127:0] cap_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (op_start) begin
        start_cnt++;
        cap_q.push_back({b_flat, a_flat});
      end
      if (frame_err) err_cnt++;
    end
  end

  always @(posedge clk) if (in_valid && in_ready) beats++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_pulse();
    op_finish = 1'b1;
    @(posedge clk);
    #1;
    op_finish = 1'b0;
    check("ready_after_finish", in_ready, 1);
    check("busy_after_finish", busy, 0);
  endtask

  typedef struct {
    logic [7:0][15:0] el;
    int               last_at;
    bit               fire;
    bit               hold;
    bit               fin_fire;
    logic [63:0]      ea;
    logic [63:0]      eb;
  } vec_t;

  vec_t tbl[5];

  task automatic do_frame(input vec_t v);
    int s0, e0, n, b0, bad_cyc;
    s0 = start_cnt;
    e0 = err_cnt;
    n = (v.last_at >= 0) ? v.last_at + 1 : 8;
    for (int i = 0; i < n; i++) send_beat(v.el[i], (i == v.last_at));
    if (v.fire) begin
      check("op_start_t1", op_start, 1);
      check("busy_t1", busy, 1);
      check("ready_t1", in_ready, 0);
      check("a_flat", a_flat, v.ea);
      check("b_flat", b_flat, v.eb);
      if (v.fin_fire) op_finish = 1'b1;
      @(posedge clk);
      #1;
      op_finish = 1'b0;
      check("op_start_t2", op_start, 0);
      check("busy_wait", busy, 1);
      check("start_count", start_cnt - s0, 1);
      check("err_count_fire", err_cnt - e0, 0);
      if (cap_q.size() > 0) check("captured", cap_q.pop_front(), {v.eb, v.ea});
      else check("captured_missing", 0, 1);
      if (v.hold) begin
        b0 = beats;
        bad_cyc = 0;
        in_valid = 1'b1;
        in_data = 16'hDEAD;
        for (int c = 0; c < 20; c++) begin
          @(posedge clk);
          #1;
          if (in_ready !== 1'b0 || busy !== 1'b1) bad_cyc++;
        end
        in_valid = 1'b0;
        check("hold_ready_low", bad_cyc, 0);
        check("hold_no_beats", beats - b0, 0);
        check("hold_a", a_flat, v.ea);
        check("hold_b", b_flat, v.eb);
      end
      finish_pulse();
    end else begin
      check("frame_err_pulse", frame_err, 1);
      check("ready_on_err", in_ready, 1);
      check("no_start_on_err", op_start, 0);
      @(posedge clk);
      #1;
      check("frame_err_clear", frame_err, 0);
      check("err_count", err_cnt - e0, 1);
      check("no_start_count", start_cnt - s0, 0);
    end
  endtask

  initial begin
    logic [15:0] e[8];
    logic [63:0] ea, eb;
    int s0;

    tbl[0] = '{el: 128'h3F80_3F80_3F80_3F80_4080_4040_4000_3F80, last_at: 7, fire: 1,
               hold: 1, fin_fire: 0, ea: 64'h4080_4040_4000_3F80, eb: 64'h3F80_3F80_3F80_3F80};
    tbl[1] = '{el: 128'h8888_7777_6666_5555_4444_3333_2222_1111, last_at: 4, fire: 0,
               hold: 0, fin_fire: 0, ea: 64'h0, eb: 64'h0};
    tbl[2] = '{el: 128'hFF80_7F80_FFFF_8000_0004_0003_0002_0001, last_at: 7, fire: 1,
               hold: 0, fin_fire: 1, ea: 64'h0004_0003_0002_0001, eb: 64'hFF80_7F80_FFFF_8000};
    tbl[3] = '{el: 128'hAAA8_AAA7_AAA6_AAA5_AAA4_AAA3_AAA2_AAA1, last_at: -1, fire: 0,
               hold: 0, fin_fire: 0, ea: 64'h0, eb: 64'h0};
    tbl[4] = '{el: 128'hDEF0_9ABC_5678_1234_7FFF_0000_BF80_C000, last_at: 7, fire: 1,
               hold: 0, fin_fire: 0, ea: 64'h7FFF_0000_BF80_C000, eb: 64'hDEF0_9ABC_5678_1234};

    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_a", a_flat, 0);
    check("rst_b", b_flat, 0);
    check("rst_ctrl", {op_start, busy, frame_err}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_low_after_release", in_ready, 0);
    @(posedge clk);
    #1;
    check("ready_high_after_release", in_ready, 1);

    for (int t = 0; t < 5; t++) do_frame(tbl[t]);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 6; i++) send_beat(tbl[2].el[i], 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {in_ready, op_start, busy, frame_err}, 0);
    check("async_rst_a", a_flat, 0);
    check("async_rst_b", b_flat, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_low_after_rst2", in_ready, 0);
    @(posedge clk);
    #1;
    check("ready_high_after_rst2", in_ready, 1);
    do_frame(tbl[4]);

    // Random gaps, scoreboard of whole frames.
    s0 = start_cnt;
    for (int f = 0; f < 100; f++) begin
      for (int k = 0; k < 8; k++) e[k] = 16'($urandom);
      ea = '0;
      eb = '0;
      for (int k = 0; k < 4; k++) begin
        ea[16*k +: 16] = e[k];
        eb[16*k +: 16] = e[k+4];
      end
      for (int k = 0; k < 8; k++) begin
        while ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1;
        end
        send_beat(e[k], (k == 7));
      end
      repeat (5) @(posedge clk);
      #1;
      op_finish = 1'b1;
      @(posedge clk);
      #1;
      op_finish = 1'b0;
      if (cap_q.size() > 0) check("rand_frame", cap_q.pop_front(), {eb, ea});
      else check("rand_frame_missing", 0, 1);
    end
    check("rand_start_count", start_cnt - s0, 100);
    check("rand_no_extra", cap_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
